alu_seq: RTL and testbench
==========================

# alu_seq

Sequential, parametrised successor to the combinational ALU, with the same eight opcodes. Operands are accepted and results returned over valid/ready handshakes. ADD/SUB/NOT/logic ops complete in one cycle; MUL (iterative shift-add) and DIV (iterative restoring) run over DATA_WIDTH cycles. The result is registered and carries zero/carry/error status. It sits between the CPU control unit and the register file, so the control unit can stall on slow ops instead of relying on a combinational multiply/divide path.

## Interface
- DATA_WIDTH, 16, operand/result width in bits (≥2)
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  operation request valid
- in_ready  out  1  block can accept a request this cycle
- oc  in  3  opcode: 000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 NOT, 101 XOR, 110 OR, 111 AND
- a  in  DATA_WIDTH  operand A (unsigned)
- b  in  DATA_WIDTH  operand B (unsigned)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- f  out  DATA_WIDTH  result
- zero  out  1  f == 0
- carry  out  1  ADD carry-out / SUB borrow (a < b), else 0
- err  out  1  DIV by zero, or DIV with divider compiled out

## Operation
- Request fires when in_valid && in_ready.
  - oc, a and b are captured; they may change afterwards.
- States:
  - IDLE:
    - in_ready=1, out_valid=0.
    - On fire: single-cycle op, or DIV with b==0, goes to DONE. MUL/DIV goes to BUSY with iteration counter = DATA_WIDTH-1.
  - BUSY:
    - in_ready=0, out_valid=0.
    - One iteration per cycle; counter decrements.
    - After the iteration at counter==0, goes to DONE.
  - DONE:
    - out_valid=1; f/zero/carry/err held stable.
    - If out_ready=1, the result is consumed.
    - in_ready = out_ready, so a back-to-back request fires in the same cycle and is handled as if issued from IDLE. Otherwise the block goes to IDLE.
- Arithmetic (all unsigned, modulo 2^DATA_WIDTH):
  - ADD: f = a+b, carry = bit DATA_WIDTH of the full sum.
  - SUB: f = a-b, carry = (a<b).
  - MUL: f = low DATA_WIDTH bits of a*b.
  - DIV: f = floor(a/b); remainder discarded.
  - DIV with b==0: f = all ones, err=1.
  - NOT: f = ~a (b ignored). XOR, OR, AND: bitwise.
- Flags:
  - zero is computed from the final f.
  - carry = 0 and err = 0 for every op not listed above.
- in_valid while BUSY or DONE with out_ready=0 is not accepted; the requester holds.

## Timing
- Reset (rst_n=0 at a rising edge):
  - state=IDLE; f=0, zero=0, carry=0, err=0, out_valid=0.
  - in_ready is 1 from the first edge with rst_n=0.
  - Requests presented while rst_n=0 are ignored.
  - Reset mid-BUSY or mid-DONE aborts the operation; the result is discarded.
- Latency, fire edge to first out_valid=1 cycle:
  - Single-cycle ops and DIV by zero: 1 cycle.
  - MUL and DIV: DATA_WIDTH+1 cycles (16 iterations plus the DONE entry at DATA_WIDTH=16 gives 17).
- Throughput with out_ready tied high:
  - Single-cycle ops: one per cycle.
  - MUL/DIV: one per DATA_WIDTH+1 cycles.
- Outputs are registered; only in_ready is combinational (from state and out_ready).
- Simultaneous consume and new request in DONE: the old result is consumed at that edge. The next edge shows the new result (single-cycle op) or enters BUSY.

## Configuration
- ALU_DIV_EN defined:
  - Iterative restoring divider is present; DIV behaves as in Operation.
- ALU_DIV_EN undefined:
  - No divider hardware.
  - DIV completes in 1 cycle with f=0, err=1, carry=0, zero=1.
  - All other ops are unchanged.

## Test plan
(DATA_WIDTH=16)
- Reset with in_valid=1 and rst_n=0 for 3 cycles, then release. Required: out_valid never rises; f=0 and all flags=0; in_ready=1.
- ADD a=0xFFFF, b=0x0001, out_ready=1. Required: next cycle out_valid=1, f=0x0000, zero=1, carry=1. Then SUB a=3, b=5 back-to-back gives f=0xFFFE, carry=1.
- MUL a=0x0123, b=0x0010. Required: in_ready=0 for 16 cycles; out_valid on cycle 17 with f=0x1230. Holding out_ready=0 for 4 cycles keeps f stable and in_ready=0.
- DIV a=1000, b=7. Required: f=142 after 17 cycles, err=0. DIV a=5, b=0 gives f=0xFFFF, err=1 after 1 cycle. Without ALU_DIV_EN, DIV a=1000, b=7 gives f=0, err=1 after 1 cycle.
- Assert rst_n=0 on cycle 8 of a MUL. Required: out_valid stays 0, IDLE after release, no stale result appears.
- Stream NOT/XOR/OR/AND with out_ready toggling every cycle. Required: every accepted request produces exactly one result, in order, with correct values (e.g. XOR 0xF0F0^0x0FF0=0xFF00).

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with valid/ready handshakes on both sides.
// ADD/SUB/NOT/XOR/OR/AND finish in one cycle. MUL (shift-add) and DIV
// (restoring) iterate once per cycle for DATA_WIDTH cycles.
// Optional feature macro: ALU_DIV_EN. When it is undefined there is no
// divider, and DIV returns f=0 with err=1 after one cycle.
module alu_seq #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            oc,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] f,
  output logic                  zero,
  output logic                  carry,
  output logic                  err
);

  localparam int CW = $clog2(DATA_WIDTH);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_NOT = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_OR  = 3'd6;
  localparam logic [2:0] OP_AND = 3'd7;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  // Iteration registers are shared by MUL and DIV:
  //   MUL: x = multiplier (shifts right), y = multiplicand (shifts left), z = accumulator
  //   DIV: x = dividend/quotient (shifts left), y = divisor, z = partial remainder
  logic [DATA_WIDTH-1:0] x, y, z;
  logic [DATA_WIDTH-1:0] x_n, y_n, z_n, it_res;
`ifdef ALU_DIV_EN
  logic                  op_div;
  logic [DATA_WIDTH:0]   r_sh;
  logic                  ge;
`endif

  // Start-of-operation decode
  logic                  fire;
  logic                  s_iter, s_carry, s_err;
  logic [DATA_WIDTH-1:0] s_f;
  logic [DATA_WIDTH:0]   sum;

  // A new request is taken from IDLE, or from DONE while the result drains.
  assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
  assign fire     = in_valid && in_ready;

  // Result and flags for ops that finish on the fire edge; flags iterative ops.
  always_comb begin
    s_f     = '0;
    s_carry = 1'b0;
    s_err   = 1'b0;
    s_iter  = 1'b0;
    sum     = {1'b0, a} + {1'b0, b};
    case (oc)
      OP_ADD: begin
        s_f     = sum[DATA_WIDTH-1:0];
        s_carry = sum[DATA_WIDTH];
      end
      OP_SUB: begin
        s_f     = a - b;
        s_carry = (a < b);
      end
      OP_MUL: s_iter = 1'b1;
      OP_DIV: begin
`ifdef ALU_DIV_EN
        if (b == '0) begin
          s_f   = '1;
          s_err = 1'b1;
        end else begin
          s_iter = 1'b1;
        end
`else
        s_err = 1'b1;
`endif
      end
      OP_NOT: s_f = ~a;
      OP_XOR: s_f = a ^ b;
      OP_OR:  s_f = a | b;
      OP_AND: s_f = a & b;
      default: s_f = '0;
    endcase
  end

  // One multiply or divide step; it_res is the final value after the last step.
  always_comb begin
    z_n    = x[0] ? (z + y) : z;
    x_n    = x >> 1;
    y_n    = y << 1;
    it_res = z_n;
`ifdef ALU_DIV_EN
    r_sh = {z, x[DATA_WIDTH-1]};
    ge   = (r_sh >= {1'b0, y});
    if (op_div) begin
      z_n    = ge ? DATA_WIDTH'(r_sh - {1'b0, y}) : r_sh[DATA_WIDTH-1:0];
      x_n    = {x[DATA_WIDTH-2:0], ge};
      y_n    = y;
      it_res = x_n;
    end
`endif
  end

  // Control FSM with registered result, flags and out_valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      x         <= '0;
      y         <= '0;
      z         <= '0;
      f         <= '0;
      zero      <= 1'b0;
      carry     <= 1'b0;
      err       <= 1'b0;
      out_valid <= 1'b0;
`ifdef ALU_DIV_EN
      op_div    <= 1'b0;
`endif
    end else begin
      case (state)
        BUSY: begin
          x   <= x_n;
          y   <= y_n;
          z   <= z_n;
          cnt <= cnt - CW'(1);
          if (cnt == '0) begin
            state     <= DONE;
            out_valid <= 1'b1;
            f         <= it_res;
            zero      <= (it_res == '0);
            carry     <= 1'b0;
            err       <= 1'b0;
          end
        end
        default: begin
          if (fire) begin
            if (s_iter) begin
              state     <= BUSY;
              out_valid <= 1'b0;
              cnt       <= CW'(DATA_WIDTH - 1);
              z         <= '0;
`ifdef ALU_DIV_EN
              op_div    <= (oc == OP_DIV);
              x         <= (oc == OP_DIV) ? a : b;
              y         <= (oc == OP_DIV) ? b : a;
`else
              x         <= b;
              y         <= a;
`endif
            end else begin
              state     <= DONE;
              out_valid <= 1'b1;
              f         <= s_f;
              zero      <= (s_f == '0);
              carry     <= s_carry;
              err       <= s_err;
            end
          end else if ((state == DONE) && out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: self-checking bench for alu_seq at DATA_WIDTH=16.
// Expected values come from an arithmetic reference model (model()).
// Honours ALU_DIV_EN the same way the design does.
module tb_alu_seq;
  localparam int DW = 16;
`ifdef ALU_DIV_EN
  localparam bit DIV_ON = 1'b1;
`else
  localparam bit DIV_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    oc = 3'd0;
  logic [DW-1:0] a = '0;
  logic [DW-1:0] b = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] f;
  logic          zero, carry, err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_seq #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .oc(oc), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .f(f), .zero(zero), .carry(carry), .err(err)
  );

  // Reference: result, flags and fire-to-out_valid latency in cycles.
  function automatic void model(input logic [2:0] o, input logic [DW-1:0] x, y,
                                output logic [DW-1:0] rf, output logic rz, rc, re,
                                output int lat);
    logic [DW:0] s;
    longint unsigned p;
    rf = '0; rc = 1'b0; re = 1'b0; lat = 1;
    case (o)
      3'd0: begin s = {1'b0, x} + {1'b0, y}; rf = s[DW-1:0]; rc = s[DW]; end
      3'd1: begin rf = x - y; rc = (x < y); end
      3'd2: begin p = longint'(x) * longint'(y); rf = p[DW-1:0]; lat = DW + 1; end
      3'd3: begin
        if (!DIV_ON) begin rf = '0; re = 1'b1; end
        else if (y == 0) begin rf = '1; re = 1'b1; end
        else begin rf = x / y; lat = DW + 1; end
      end
      3'd4: rf = ~x;
      3'd5: rf = x ^ y;
      3'd6: rf = x | y;
      default: rf = x & y;
    endcase
    rz = (rf == 0);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drain any pending result and return to IDLE.
  task automatic settle();
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    step();
  endtask

  // Issue one request; report cycles waited for acceptance, latency and outputs.
  task automatic run_op(input logic [2:0] o, input logic [DW-1:0] x, y,
                        output logic [DW-1:0] rf, output logic rz, rc, re,
                        output int wt, output int lat);
    oc = o; a = x; b = y; in_valid = 1'b1;
    wt = 0;
    while (in_ready !== 1'b1 && wt < 100) begin step(); wt++; end
    step();
    in_valid = 1'b0;
    oc = 3'($urandom); a = DW'($urandom); b = DW'($urandom);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 64) begin step(); lat++; end
    rf = f; rz = zero; rc = carry; re = err;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; oc = 3'd0; a = 16'h1234; b = 16'h0001; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b0 || f !== 16'h0 || zero !== 1'b0 || carry !== 1'b0 ||
          err !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d: out_valid=%b f=%h z=%b c=%b e=%b in_ready=%b, need 0 0000 0 0 0 1",
                 i, out_valid, f, zero, carry, err, in_ready);
      end
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || f !== 16'h0) begin
      errors++;
      $display("FAIL reset_release: out_valid=%b in_ready=%b f=%h, need 0 1 0000", out_valid, in_ready, f);
    end
  endtask

  task automatic test_add_sub();
    logic [DW-1:0] rf; logic rz, rc, re; int wt, lat;
    settle();
    run_op(3'd0, 16'hFFFF, 16'h0001, rf, rz, rc, re, wt, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL add_latency: got %0d need 1", lat); end
    checks++; if (rf !== 16'h0000) begin errors++; $display("FAIL add_f: got %h need 0000", rf); end
    checks++; if (rz !== 1'b1 || rc !== 1'b1 || re !== 1'b0) begin
      errors++; $display("FAIL add_flags: z=%b c=%b e=%b need 1 1 0", rz, rc, re); end
    run_op(3'd1, 16'd3, 16'd5, rf, rz, rc, re, wt, lat);
    checks++; if (wt !== 0 || lat !== 1) begin
      errors++; $display("FAIL sub_back_to_back: wait=%0d lat=%0d need 0 1", wt, lat); end
    checks++; if (rf !== 16'hFFFE || rc !== 1'b1 || rz !== 1'b0 || re !== 1'b0) begin
      errors++; $display("FAIL sub_result: f=%h c=%b z=%b e=%b need fffe 1 0 0", rf, rc, rz, re); end
  endtask

  task automatic test_mul();
    int busy;
    logic [DW-1:0] rf, ef; logic rz, rc, re, ez, ec, ee; int wt, lat, el;
    settle();
    out_ready = 1'b0;
    oc = 3'd2; a = 16'h0123; b = 16'h0010; in_valid = 1'b1;
    step();
    in_valid = 1'b0; a = 16'hAAAA; b = 16'h5555; oc = 3'd0;
    busy = 0;
    for (int i = 0; i < 16; i++) begin
      if (in_ready === 1'b0 && out_valid === 1'b0) busy++;
      step();
    end
    checks++; if (busy !== 16) begin errors++; $display("FAIL mul_busy_cycles: got %0d need 16", busy); end
    checks++; if (out_valid !== 1'b1 || f !== 16'h1230) begin
      errors++; $display("FAIL mul_result: out_valid=%b f=%h need 1 1230", out_valid, f); end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || f !== 16'h1230 || in_ready !== 1'b0) begin
        errors++; $display("FAIL mul_hold cyc=%0d: out_valid=%b f=%h in_ready=%b need 1 1230 0",
                           i, out_valid, f, in_ready);
      end
    end
    out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL mul_consume: out_valid=%b in_ready=%b need 0 1", out_valid, in_ready); end
    for (int i = 0; i < 4; i++) begin
      a = DW'($urandom); b = DW'($urandom);
      if (i == 0) begin a = 16'hFFFF; b = 16'hFFFF; end
      model(3'd2, a, b, ef, ez, ec, ee, el);
      run_op(3'd2, a, b, rf, rz, rc, re, wt, lat);
      checks++;
      if (rf !== ef || rz !== ez || rc !== ec || re !== ee || lat !== el) begin
        errors++; $display("FAIL mul_rand %0d: got f=%h z%b c%b e%b lat%0d need f=%h z%b c%b e%b lat%0d",
                           i, rf, rz, rc, re, lat, ef, ez, ec, ee, el);
      end
    end
  endtask

  task automatic test_div();
    logic [DW-1:0] rf, ef, xa, xb; logic rz, rc, re, ez, ec, ee; int wt, lat, el;
    settle();
    run_op(3'd3, 16'd1000, 16'd7, rf, rz, rc, re, wt, lat);
    checks++;
    if (rf !== (DIV_ON ? 16'd142 : 16'd0) || re !== !DIV_ON || rz !== !DIV_ON || rc !== 1'b0 ||
        lat !== (DIV_ON ? 17 : 1)) begin
      errors++; $display("FAIL div_1000_7: f=%0d e=%b z=%b c=%b lat=%0d need f=%0d e=%b z=%b c=0 lat=%0d",
                         rf, re, rz, rc, lat, DIV_ON ? 142 : 0, !DIV_ON, !DIV_ON, DIV_ON ? 17 : 1);
    end
    run_op(3'd3, 16'd5, 16'd0, rf, rz, rc, re, wt, lat);
    checks++;
    if (rf !== (DIV_ON ? 16'hFFFF : 16'h0) || re !== 1'b1 || lat !== 1) begin
      errors++; $display("FAIL div_by_zero: f=%h e=%b lat=%0d need f=%h e=1 lat=1",
                         rf, re, lat, DIV_ON ? 16'hFFFF : 16'h0);
    end
    for (int i = 0; i < 6; i++) begin
      xa = DW'($urandom); xb = DW'($urandom_range(1, (i < 3) ? 20 : 65535));
      if (i == 0) begin xa = 16'd6; xb = 16'd7; end
      if (i == 1) begin xa = 16'hFFFF; xb = 16'd1; end
      model(3'd3, xa, xb, ef, ez, ec, ee, el);
      run_op(3'd3, xa, xb, rf, rz, rc, re, wt, lat);
      checks++;
      if (rf !== ef || rz !== ez || rc !== ec || re !== ee || lat !== el) begin
        errors++; $display("FAIL div_rand %h/%h: got f=%h z%b e%b lat%0d need f=%h z%b e%b lat%0d",
                           xa, xb, rf, rz, re, lat, ef, ez, ee, el);
      end
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    settle();
    oc = 3'd2; a = 16'h0123; b = 16'h0010; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (7) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++; if (out_valid !== 1'b0 || f !== 16'h0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL midreset_state: out_valid=%b f=%h in_ready=%b need 0 0000 1", out_valid, f, in_ready); end
    seen = 0;
    for (int i = 0; i < 24; i++) begin
      step();
      if (out_valid !== 1'b0 || in_ready !== 1'b1) seen++;
    end
    checks++; if (seen !== 0) begin
      errors++; $display("FAIL midreset_stale: %0d cycles with out_valid/busy, need 0", seen); end
  endtask

  task automatic test_stream();
    logic [DW-1:0] q[$];
    logic [DW-1:0] ef, got, exp_f; logic ez, ec, ee; int el;
    logic fire, cons;
    int nreq, nres, guard;
    settle();
    nreq = 0; nres = 0;
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      out_ready = ~out_ready;
      if (!in_valid) begin
        if (nreq == 0) begin
          oc = 3'd5; a = 16'hF0F0; b = 16'h0FF0; in_valid = 1'b1;
        end else if (($urandom % 4) != 0) begin
          oc = 3'(4 + ($urandom % 4)); a = DW'($urandom); b = DW'($urandom); in_valid = 1'b1;
        end
      end
      #1;
      fire = in_valid && in_ready;
      cons = out_valid && out_ready;
      got = f;
      if (fire) model(oc, a, b, ef, ez, ec, ee, el);
      step();
      if (cons) begin
        nres++;
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL stream_extra_result: f=%h with no outstanding request", got);
        end else begin
          exp_f = q.pop_front();
          if (got !== exp_f) begin
            errors++; $display("FAIL stream_value #%0d: got %h need %h", nres, got, exp_f);
          end
        end
      end
      if (fire) begin
        q.push_back(ef);
        nreq++;
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    guard = 0;
    while (q.size() != 0 && guard < 10) begin
      #1;
      cons = out_valid;
      got = f;
      step();
      guard++;
      if (cons) begin
        nres++;
        exp_f = q.pop_front();
        checks++;
        if (got !== exp_f) begin
          errors++; $display("FAIL stream_drain #%0d: got %h need %h", nres, got, exp_f);
        end
      end
    end
    checks++; if (nres !== nreq || nreq < 20) begin
      errors++; $display("FAIL stream_count: results=%0d requests=%0d (need equal, >=20)", nres, nreq); end
  endtask

  task automatic test_random_all();
    logic [DW-1:0] rf, ef, xa, xb; logic [2:0] o; logic rz, rc, re, ez, ec, ee; int wt, lat, el;
    settle();
    for (int i = 0; i < 30; i++) begin
      o = 3'($urandom); xa = DW'($urandom); xb = DW'($urandom);
      if (($urandom % 8) == 0) xb = 16'h0;
      if (($urandom % 8) == 0) xb = xa;
      model(o, xa, xb, ef, ez, ec, ee, el);
      run_op(o, xa, xb, rf, rz, rc, re, wt, lat);
      checks++;
      if (rf !== ef || rz !== ez || rc !== ec || re !== ee || lat !== el || wt !== 0) begin
        errors++; $display("FAIL rand op=%0d a=%h b=%h: got f=%h z%b c%b e%b lat%0d wt%0d need f=%h z%b c%b e%b lat%0d wt0",
                           o, xa, xb, rf, rz, rc, re, lat, wt, ef, ez, ec, ee, el);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_mul();
    test_div();
    test_reset_mid();
    test_stream();
    test_random_all();
    settle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not complete within time limit");
    $fatal(1, "timeout");
  end

endmodule
